sram_march_bist_ctrl: RTL and testbench
=======================================

Name: sram_march_bist_ctrl

Overview:
- March C- built-in self-test controller for one single-port SRAM macro with BIST port, default 256x16 with bit mask.
- Drives the macro's BIST enable, command, address, data and mask pins, and checks read data against expected values.
- Reports pass/fail, an error count and first-failure diagnostics to the test/DFT register block.
- Sits beside the macro; the SoC DFT controller starts and aborts it.

Parameters:
- DW, 16, data/mask width
- AW, 8, address width; depth = 2**AW

Ports:
- clk_i  in  1  clock; the macro's BIST clock is tied to the same net
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse/level; launches a test when in IDLE or DONE
- abort_i  in  1  stops the test and returns to IDLE; has priority over start_i
- bg_i  in  DW  data background; pattern "0" = bg_i, pattern "1" = ~bg_i; sampled at start
- busy_o  out  1  test in progress (RUN or CHECK)
- done_o  out  1  test complete; sticky until next start, abort or reset
- pass_o  out  1  done_o and no mismatch
- fail_o  out  1  at least one mismatch since start; sticky
- err_cnt_o  out  8  mismatch count, saturating at 255
- fail_addr_o  out  AW  address of the first mismatch
- fail_elem_o  out  3  march element index (0-5) of the first mismatch
- fail_syn_o  out  DW  XOR of expected and read data at the first mismatch
- bist_en_o  out  1  to A_BIST_EN; selects the BIST port
- bist_men_o, bist_wen_o, bist_ren_o  out  1 each  to A_BIST_MEN/WEN/REN
- bist_addr_o  out  AW  to A_BIST_ADDR
- bist_din_o  out  DW  to A_BIST_DIN
- bist_bm_o  out  DW  to A_BIST_BM
- bist_dout_i  in  DW  from A_DOUT

Behaviour:
- All outputs are registered.
- Reset: every output is 0; state IDLE; bg register 0.
- States:
  - IDLE: start_i -> RUN; load bg, clear err_cnt, fail, done and diagnostics.
  - RUN: issue one SRAM op per cycle; after the last op -> CHECK.
  - CHECK: one cycle, men=0, compares the final read -> DONE.
  - DONE: done_o=1; start_i -> RUN, same as from IDLE.
- abort_i in any state -> IDLE next edge, all bist_* outputs 0. Flags are cleared and done_o=0.
- start_i is ignored while busy_o=1.
- March C- elements (N = 2**AW), ascending = addr 0..N-1, descending = N-1..0:
  - E0 asc w0
  - E1 asc r0,w1
  - E2 asc r1,w0
  - E3 desc r0,w1
  - E4 desc r1,w0
  - E5 asc r0
- Within E1-E4 the read and write of one address occupy consecutive cycles, read first.
- Total RUN = 10N cycles (2560 at default).
- Command encoding:
  - read: men=1, ren=1, wen=0, bm=0.
  - write: men=1, wen=1, ren=0, bm=all-ones, din=pattern.
- Timing: start sampled at edge t0 -> E0 addr 0 write presented from t0.
  - Last op presented at t0+2559 cycles.
  - CHECK at t0+2560; done_o/pass_o high from t0+2561.
  - bist_en_o=1 through RUN and CHECK, 0 in IDLE and DONE.
- Compare pipeline:
  - A read presented in cycle k is sampled by the macro at the end of cycle k; DOUT is valid in cycle k+1.
  - The controller compares at the edge ending cycle k+1, against expected data, address and element delayed one cycle.
  - Only read cycles are compared.
- Mismatch handling:
  - err_cnt increments by 1 per mismatching read and saturates at 255.
  - The first mismatch captures addr, elem and syndrome; later mismatches do not overwrite them.
  - fail_o is set on the same edge as the first capture.
- Address counter: wraps at element boundaries only; no mid-element wrap.
- Reset mid-run: immediate return to reset values; bist_en_o drops asynchronously.

Test Plan:
- Fault-free SRAM model, bg=0x0000, start pulse -> busy 2561 cycles, done=1, pass=1, err_cnt=0; write count 1280, read count 1280.
- Bit 3 of addr 0x2A stuck-at-1, bg=0x0000 -> fail=1, fail_elem=1, fail_addr=0x2A, fail_syn=0x0008, err_cnt=3 (E1, E3, E5).
- Same fault, bg=0xFFFF -> first failure in E2, fail_addr=0x2A, fail_syn=0x0008, err_cnt=2.
- DOUT forced to 0xA5A5, bg=0x0000 -> fail_elem=1, fail_addr=0x00, fail_syn=0xA5A5, err_cnt saturates at 255; done still at t0+2561.
- Address trace check -> E3 and E4 present addresses 0xFF down to 0x00, each as an r/w pair; E0/E5 ascending.
- abort_i at cycle 700 -> IDLE next edge, bist_en_o=0, done_o=0; then start -> full clean run.
- rst_ni low at cycle 1500 -> all outputs 0 immediately; start after release -> full clean run.

Source files
------------

// File: rtl/sram_march_bist_ctrl_if.sv
// BIST-port bus between the March C- controller and one single-port SRAM macro.
// The controller is the master; the macro (or its model) is the slave.
interface sram_march_bist_ctrl_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 8
);
   logic          bist_en;
   logic          bist_men;
   logic          bist_wen;
   logic          bist_ren;
   logic [AW-1:0] bist_addr;
   logic [DW-1:0] bist_din;
   logic [DW-1:0] bist_bm;
   logic [DW-1:0] bist_dout;

   modport master (
      output bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
      input  bist_dout
   );

   modport slave (
      input  bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
      output bist_dout
   );
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller: sequences one SRAM op per cycle, compares read data one
// cycle after the macro samples it, and keeps sticky pass/fail and first-fail diagnostics.
module sram_march_bist_ctrl #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [DW-1:0]          bg_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic                   fail_o,
   output logic [7:0]             err_cnt_o,
   output logic [AW-1:0]          fail_addr_o,
   output logic [2:0]             fail_elem_o,
   output logic [DW-1:0]          fail_syn_o,
   sram_march_bist_ctrl_if.master bist
);

   typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

   state_e        state_q, state_d;
   logic [2:0]    elem_q, elem_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wr_ph_q, wr_ph_d;
   logic [DW-1:0] bg_q, bg_d;

   logic          en_q, en_d, men_q, men_d, wen_q, wen_d, ren_q, ren_d;
   logic [DW-1:0] din_q, din_d, bm_q, bm_d, exp_q, exp_d;

   logic          cmp_vld_q, cmp_vld_d;
   logic [DW-1:0] cmp_exp_q, cmp_exp_d;
   logic [AW-1:0] cmp_addr_q, cmp_addr_d;
   logic [2:0]    cmp_elem_q, cmp_elem_d;

   logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
   logic [7:0]    err_q, err_d;
   logic [AW-1:0] faddr_q, faddr_d;
   logic [2:0]    felem_q, felem_d;
   logic [DW-1:0] fsyn_q, fsyn_d;

   logic          desc, pair, nxt_desc, is_wr, pat1, launch, mis;
   logic [2:0]    nxt_elem;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] data, syn;

   // Sequencer: (elem, addr, wr_ph) names the op presented in the next cycle.
   always_comb begin
      state_d   = state_q;
      elem_d    = elem_q;
      addr_d    = addr_q;
      wr_ph_d   = wr_ph_q;
      bg_d      = bg_q;
      desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
      pair      = (elem_q >= 3'd1) && (elem_q <= 3'd4);
      nxt_elem  = elem_q + 3'd1;
      nxt_desc  = (nxt_elem == 3'd3) || (nxt_elem == 3'd4);
      last_addr = desc ? '0 : '1;
      launch    = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               launch  = 1'b1;
               state_d = StRun;
               elem_d  = 3'd0;
               addr_d  = '0;
               wr_ph_d = 1'b0;
               bg_d    = bg_i;
            end
         end
         StRun: begin
            if (pair && !wr_ph_q) begin
               wr_ph_d = 1'b1;
            end else begin
               wr_ph_d = 1'b0;
               if (addr_q == last_addr) begin
                  if (elem_q == 3'd5) begin
                     state_d = StCheck;
                     elem_d  = 3'd0;
                     addr_d  = '0;
                  end else begin
                     elem_d = nxt_elem;
                     addr_d = nxt_desc ? '1 : '0;
                  end
               end else begin
                  addr_d = desc ? addr_q - 1'b1 : addr_q + 1'b1;
               end
            end
         end
         StCheck: state_d = StDone;
         default: state_d = StIdle;
      endcase
      if (abort_i) begin
         state_d = StIdle;
         elem_d  = 3'd0;
         addr_d  = '0;
         wr_ph_d = 1'b0;
         launch  = 1'b0;
      end
   end

   // Macro pins are registered straight from the next op so they line up with addr_q.
   always_comb begin
      is_wr = (elem_d == 3'd0) || ((elem_d >= 3'd1) && (elem_d <= 3'd4) && wr_ph_d);
      pat1  = is_wr ? ((elem_d == 3'd1) || (elem_d == 3'd3))
                    : ((elem_d == 3'd2) || (elem_d == 3'd4));
      data  = pat1 ? ~bg_d : bg_d;
      en_d  = (state_d == StRun) || (state_d == StCheck);
      men_d = (state_d == StRun);
      wen_d = men_d && is_wr;
      ren_d = men_d && !is_wr;
      din_d = wen_d ? data : '0;
      bm_d  = wen_d ? '1 : '0;
      exp_d = ren_d ? data : '0;
   end

   // Compare stage sees the read presented two edges earlier, now on bist_dout.
   always_comb begin
      cmp_vld_d  = ren_q && !abort_i;
      cmp_exp_d  = exp_q;
      cmp_addr_d = addr_q;
      cmp_elem_d = elem_q;
      syn        = bist.bist_dout ^ cmp_exp_q;
      mis        = cmp_vld_q && (syn != '0);
      err_d      = err_q;
      fail_d     = fail_q;
      faddr_d    = faddr_q;
      felem_d    = felem_q;
      fsyn_d     = fsyn_q;
      if (abort_i || launch) begin
         err_d   = '0;
         fail_d  = 1'b0;
         faddr_d = '0;
         felem_d = '0;
         fsyn_d  = '0;
      end else if (mis) begin
         if (err_q != 8'hFF) err_d = err_q + 8'd1;
         if (!fail_q) begin
            faddr_d = cmp_addr_q;
            felem_d = cmp_elem_q;
            fsyn_d  = syn;
         end
         fail_d = 1'b1;
      end
      busy_d = en_d;
      done_d = (state_d == StDone);
      pass_d = done_d && !fail_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         elem_q     <= '0;
         addr_q     <= '0;
         wr_ph_q    <= 1'b0;
         bg_q       <= '0;
         en_q       <= 1'b0;
         men_q      <= 1'b0;
         wen_q      <= 1'b0;
         ren_q      <= 1'b0;
         din_q      <= '0;
         bm_q       <= '0;
         exp_q      <= '0;
         cmp_vld_q  <= 1'b0;
         cmp_exp_q  <= '0;
         cmp_addr_q <= '0;
         cmp_elem_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         err_q      <= '0;
         faddr_q    <= '0;
         felem_q    <= '0;
         fsyn_q     <= '0;
      end else begin
         state_q    <= state_d;
         elem_q     <= elem_d;
         addr_q     <= addr_d;
         wr_ph_q    <= wr_ph_d;
         bg_q       <= bg_d;
         en_q       <= en_d;
         men_q      <= men_d;
         wen_q      <= wen_d;
         ren_q      <= ren_d;
         din_q      <= din_d;
         bm_q       <= bm_d;
         exp_q      <= exp_d;
         cmp_vld_q  <= cmp_vld_d;
         cmp_exp_q  <= cmp_exp_d;
         cmp_addr_q <= cmp_addr_d;
         cmp_elem_q <= cmp_elem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         err_q      <= err_d;
         faddr_q    <= faddr_d;
         felem_q    <= felem_d;
         fsyn_q     <= fsyn_d;
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign pass_o         = pass_q;
   assign fail_o         = fail_q;
   assign err_cnt_o      = err_q;
   assign fail_addr_o    = faddr_q;
   assign fail_elem_o    = felem_q;
   assign fail_syn_o     = fsyn_q;
   assign bist.bist_en   = en_q;
   assign bist.bist_men  = men_q;
   assign bist.bist_wen  = wen_q;
   assign bist.bist_ren  = ren_q;
   assign bist.bist_addr = addr_q;
   assign bist.bist_din  = din_q;
   assign bist.bist_bm   = bm_q;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl: SRAM model with injectable faults, and a loop-level
// March C- reference that predicts the op trace, error count and first-fail diagnostics.
module tb_sram_march_bist_ctrl;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 8;
   localparam int N = 256;
   localparam int NOPS = 10 * N;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } op_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [DW-1:0] bg = '0;
   logic          busy, done, pass, fail;
   logic [7:0]    err_cnt;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;
   logic [DW-1:0] fail_syn;

   sram_march_bist_ctrl_if #(.DW(DW), .AW(AW)) bif ();

   sram_march_bist_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .bg_i        (bg),
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .fail_o      (fail),
      .err_cnt_o   (err_cnt),
      .fail_addr_o (fail_addr),
      .fail_elem_o (fail_elem),
      .fail_syn_o  (fail_syn),
      .bist        (bif)
   );

   always #5 clk = ~clk;

   // Fault configuration, shared by the SRAM model and the reference.
   logic          f_on = 1'b0, f_val = 1'b0, force_on = 1'b0;
   logic [AW-1:0] f_addr = '0;
   logic [DW-1:0] f_mask = '0, force_val = '0;

   function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
      if (force_on) return force_val;
      if (f_on && a == f_addr) return f_val ? (v | f_mask) : (v & ~f_mask);
      return v;
   endfunction

   logic [DW-1:0] mem [N];
   always @(posedge clk) begin
      if (bif.bist_en && bif.bist_men) begin
         if (bif.bist_wen)
            mem[bif.bist_addr] <= (mem[bif.bist_addr] & ~bif.bist_bm) | (bif.bist_din & bif.bist_bm);
         if (bif.bist_ren) bif.bist_dout <= faulty(bif.bist_addr, mem[bif.bist_addr]);
      end
   end

   // Reference: March C- as plain loops; -1 means no read/write in that element.
   int rdp [6] = '{-1, 0, 1, 0, 1, 0};
   int wrp [6] = '{0, 1, 0, 1, 0, -1};
   op_t           exp_ops [NOPS];
   int            ref_err;
   logic          ref_fail;
   logic [AW-1:0] ref_addr;
   logic [2:0]    ref_elem;
   logic [DW-1:0] ref_syn;

   task automatic ref_march(input logic [DW-1:0] b);
      logic [DW-1:0] m [N];
      logic [DW-1:0] ev, got;
      logic [AW-1:0] aa;
      int k = 0;
      ref_err = 0; ref_fail = 1'b0; ref_addr = '0; ref_elem = '0; ref_syn = '0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            aa = AW'((e == 3 || e == 4) ? N - 1 - i : i);
            if (rdp[e] >= 0) begin
               ev = (rdp[e] == 1) ? ~b : b;
               got = faulty(aa, m[aa]);
               exp_ops[k] = '{we: 1'b0, addr: aa, data: ev};
               k++;
               if (got != ev) begin
                  if (!ref_fail) begin
                     ref_addr = aa; ref_elem = 3'(e); ref_syn = got ^ ev;
                  end
                  ref_fail = 1'b1;
                  if (ref_err < 255) ref_err++;
               end
            end
            if (wrp[e] >= 0) begin
               m[aa] = (wrp[e] == 1) ? ~b : b;
               exp_ops[k] = '{we: 1'b1, addr: aa, data: m[aa]};
               k++;
            end
         end
      end
   endtask

   // Trace monitor: every presented op must match the reference sequence.
   logic mon_en = 1'b0;
   int   base_ops = 0;
   int   ops_seen = 0, wr_seen = 0, rd_seen = 0, trace_err = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (bif.bist_en !== busy) trace_err++;
         if (bif.bist_men) begin
            if (ops_seen - base_ops >= NOPS) trace_err++;
            else if (bif.bist_wen !== exp_ops[ops_seen - base_ops].we ||
                     bif.bist_ren !== !exp_ops[ops_seen - base_ops].we ||
                     bif.bist_addr !== exp_ops[ops_seen - base_ops].addr ||
                     (bif.bist_wen && (bif.bist_din !== exp_ops[ops_seen - base_ops].data ||
                                       bif.bist_bm !== '1)) ||
                     (bif.bist_ren && bif.bist_bm !== '0))
               trace_err++;
            ops_seen++;
            if (bif.bist_wen) wr_seen++;
            if (bif.bist_ren) rd_seen++;
         end
      end
   end

   int n_chk = 0, n_pass = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
   endtask

   task automatic run_march(input string tag, input logic [DW-1:0] b);
      int b_ops, b_wr, b_rd, b_te, n_busy, n_cyc;
      ref_march(b);
      b_ops = ops_seen; b_wr = wr_seen; b_rd = rd_seen; b_te = trace_err;
      base_ops = ops_seen;
      @(negedge clk);
      bg = b; start = 1'b1; mon_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_busy = 0; n_cyc = 0;
      while (!done && n_cyc < 3000) begin
         if (busy) n_busy++;
         n_cyc++;
         @(negedge clk);
      end
      mon_en = 1'b0;
      check({tag, "_cyc_to_done"}, 32'(n_cyc), 32'(NOPS + 1));
      check({tag, "_busy_cycles"}, 32'(n_busy), 32'(NOPS + 1));
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
      check({tag, "_bist_en_off"}, 32'(bif.bist_en), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'(!ref_fail));
      check({tag, "_fail"}, 32'(fail), 32'(ref_fail));
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(ref_err));
      check({tag, "_fail_addr"}, 32'(fail_addr), 32'(ref_addr));
      check({tag, "_fail_elem"}, 32'(fail_elem), 32'(ref_elem));
      check({tag, "_fail_syn"}, 32'(fail_syn), 32'(ref_syn));
      check({tag, "_trace_err"}, 32'(trace_err - b_te), 32'd0);
      check({tag, "_ops"}, 32'(ops_seen - b_ops), 32'(NOPS));
      check({tag, "_writes"}, 32'(wr_seen - b_wr), 32'(NOPS / 2));
      check({tag, "_reads"}, 32'(rd_seen - b_rd), 32'(NOPS / 2));
   endtask

   task automatic clear_faults();
      f_on = 1'b0; force_on = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_fail", 32'(fail), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      check("rst_bist_en", 32'(bif.bist_en), 32'd0);
      check("rst_men", 32'(bif.bist_men), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_march("clean", 16'h0000);

      f_on = 1'b1; f_addr = 8'h2A; f_mask = 16'h0008; f_val = 1'b1;
      run_march("sa1_bg0", 16'h0000);
      check("sa1_bg0_err_lit", 32'(err_cnt), 32'd3);
      check("sa1_bg0_elem_lit", 32'(fail_elem), 32'd1);
      run_march("sa1_bgF", 16'hFFFF);
      check("sa1_bgF_err_lit", 32'(err_cnt), 32'd2);
      check("sa1_bgF_elem_lit", 32'(fail_elem), 32'd2);
      check("sa1_bgF_syn_lit", 32'(fail_syn), 32'h0008);
      clear_faults();

      force_on = 1'b1; force_val = 16'hA5A5;
      run_march("force", 16'h0000);
      check("force_err_sat", 32'(err_cnt), 32'd255);
      check("force_syn_lit", 32'(fail_syn), 32'hA5A5);
      clear_faults();

      for (int r = 0; r < 6; r++) begin
         f_on   = ($urandom_range(0, 3) != 0);
         f_addr = AW'($urandom_range(0, N - 1));
         f_mask = DW'(1) << $urandom_range(0, DW - 1);
         f_val  = 1'($urandom_range(0, 1));
         run_march($sformatf("rnd%0d", r), DW'($urandom));
      end
      clear_faults();

      // Abort mid-run with errors accumulated, then a clean run from IDLE.
      force_on = 1'b1; force_val = 16'hA5A5;
      @(negedge clk);
      bg = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (699) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_bist_en", 32'(bif.bist_en), 32'd0);
      check("abort_men", 32'(bif.bist_men), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_fail", 32'(fail), 32'd0);
      check("abort_err", 32'(err_cnt), 32'd0);
      clear_faults();
      run_march("post_abort", 16'h5A3C);

      // Asynchronous reset mid-run.
      force_on = 1'b1; force_val = 16'hA5A5;
      @(negedge clk);
      bg = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (1499) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_bist_en", 32'(bif.bist_en), 32'd0);
      check("arst_men", 32'(bif.bist_men), 32'd0);
      check("arst_wen_ren", 32'({bif.bist_wen, bif.bist_ren}), 32'd0);
      check("arst_addr", 32'(bif.bist_addr), 32'd0);
      check("arst_din", 32'(bif.bist_din), 32'd0);
      check("arst_fail", 32'(fail), 32'd0);
      check("arst_err", 32'(err_cnt), 32'd0);
      check("arst_fail_syn", 32'(fail_syn), 32'd0);
      clear_faults();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_march("post_rst", 16'h0F0F);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
